// File: rtl/tx_serializer_pkg.sv
// Shared UART definitions: line-state encoding, word-length codes, captured frame config.
// No latency of its own; helpers are pure combinational functions.
// No flow control here; imported by both the transmitter and the receiver.
package tx_serializer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } uart_state_t;

    typedef enum logic [1:0] {
        WL_5 = 2'b00,
        WL_6 = 2'b01,
        WL_7 = 2'b10,
        WL_8 = 2'b11
    } word_len_t;

    typedef struct packed {
        word_len_t wlen;
        logic      two_stop;
        logic      par_en;
        logic      par_bit;
    } frame_cfg_t;

    function automatic logic [7:0] data_mask(input word_len_t wlen);
        case (wlen)
            WL_5:    return 8'h1F;
            WL_6:    return 8'h3F;
            WL_7:    return 8'h7F;
            default: return 8'hFF;
        endcase
    endfunction

    // Index of the final data bit: 4..7 for 5..8-bit words.
    function automatic logic [2:0] last_data_idx(input word_len_t wlen);
        return {1'b1, wlen};
    endfunction

    function automatic logic parity_bit(input logic [7:0] data, input word_len_t wlen,
                                        input logic even, input logic stick);
        logic x;
        x = ^(data & data_mask(wlen));
        if (stick) return ~even;
        return even ? x : ~x;
    endfunction

endpackage

// File: rtl/tx_baud_counter.sv
// Bit-period timer: loads period-1 (period 0 treated as 1), counts down, auto-reloads at 0.
// tick is combinational from the count register; first tick period cycles after load.
// No backpressure; free-running between loads.
module tx_baud_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] period,
    output logic         tick
);

    logic [W-1:0] period_m1;
    logic [W-1:0] reload_q;
    logic [W-1:0] cnt_q;

    assign period_m1 = (period == '0) ? '0 : period - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload_q <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            reload_q <= period_m1;
            cnt_q    <= period_m1;
        end else if (cnt_q == '0) begin
            cnt_q    <= reload_q;
        end else begin
            cnt_q    <= cnt_q - 1'b1;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/tx_serializer.sv
// UART transmitter: pops bytes from an upstream FIFO and serialises start/data/parity/stop.
// Start bit begins 2 cycles after the pop strobe; Sout is registered (break adds 1 cycle).
// Pops only when FifoEmpty=0; back-to-back frames with no idle bit while data is queued.
module tx_serializer
    import tx_serializer_pkg::*;
#(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic [DIV_WIDTH-1:0] Divisor,
    input  logic [1:0]           WordLen,
    input  logic                 TwoStop,
    input  logic                 ParEn,
    input  logic                 ParEven,
    input  logic                 ParStick,
    input  logic                 SetBreak,
    input  logic                 FifoEmpty,
    input  logic [7:0]           FifoQ,
    output logic                 FifoRdEn,
    output logic                 Sout,
    output logic                 TxBusy,
    output logic                 TxDone
);

    uart_state_t state_q, state_d;
    frame_cfg_t  cfg_q, cfg_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        stop2_q, stop2_d;
    logic        line_q, line_d;
    logic        sout_q;
    logic        run_q;
    logic        cnt_load;
    logic        tick;
    logic        rd_en;
    logic        done;

    tx_baud_counter #(.W(DIV_WIDTH)) u_baud (
        .clk    (Clock),
        .rst_n  (Reset_n),
        .load   (cnt_load),
        .period (Divisor),
        .tick   (tick)
    );

    // line_d is the frame line level for the next cycle; Sout registers it so
    // every transition lands exactly on a bit boundary.
    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        stop2_d   = stop2_q;
        line_d    = line_q;
        cnt_load  = 1'b0;
        rd_en     = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                line_d = 1'b1;
                if (run_q && !FifoEmpty) begin
                    rd_en   = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_load       = 1'b1;
                shreg_d        = FifoQ;
                cfg_d.wlen     = word_len_t'(WordLen);
                cfg_d.two_stop = TwoStop;
                cfg_d.par_en   = ParEn;
                cfg_d.par_bit  = parity_bit(FifoQ, word_len_t'(WordLen), ParEven, ParStick);
                bit_idx_d      = 3'd0;
                stop2_d        = 1'b0;
                line_d         = 1'b0;
                state_d        = ST_START;
            end
            ST_START: begin
                if (tick) begin
                    line_d  = shreg_q[0];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx_q == last_data_idx(cfg_q.wlen)) begin
                        if (cfg_q.par_en) begin
                            line_d  = cfg_q.par_bit;
                            state_d = ST_PARITY;
                        end else begin
                            line_d  = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shreg_d   = {1'b0, shreg_q[7:1]};
                        line_d    = shreg_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    line_d  = 1'b1;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                line_d = 1'b1;
                if (tick) begin
                    if (cfg_q.two_stop && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        done = 1'b1;
                        if (!FifoEmpty) begin
                            rd_en   = 1'b1;
                            state_d = ST_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // run_q holds off the first pop until the cycle after reset release.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            cfg_q     <= '0;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            stop2_q   <= 1'b0;
            line_q    <= 1'b1;
            sout_q    <= 1'b1;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            stop2_q   <= stop2_d;
            line_q    <= line_d;
            sout_q    <= line_d & ~SetBreak;
            run_q     <= 1'b1;
        end
    end

    assign FifoRdEn = rd_en;
    assign TxDone   = done;
    assign TxBusy   = rd_en | (state_q != ST_IDLE);
    assign Sout     = sout_q;

endmodule

// File: doc/tx_serializer.md
TX_SERIALIZER -- requirements
Module: tx_serializer

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 16, bit width of the baud divisor.
REQ-002 SHALL have port Clock  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Divisor  input  DIV_WIDTH  Clock cycles per serial bit; 0 treated as 1.
REQ-005 SHALL have port WordLen  input  2  data bits: 00=5, 01=6, 10=7, 11=8.
REQ-006 SHALL have port TwoStop  input  1  1 = two stop bits, 0 = one.
REQ-007 SHALL have port ParEn, ParEven, ParStick  input  1 each  parity enable, even select, stick select.
REQ-008 SHALL have port SetBreak  input  1  force Sout low while high.
REQ-009 SHALL have port FifoEmpty  input  1  empty flag of the upstream 16-deep TX FIFO.
REQ-010 SHALL have port FifoQ  input  8  FIFO read data, valid the cycle after FifoRdEn.
REQ-011 SHALL have port FifoRdEn  output  1  single-cycle FIFO pop strobe.
REQ-012 SHALL have port Sout  output  1  serial line, idle high.
REQ-013 SHALL have port TxBusy  output  1  high from FifoRdEn through end of last stop bit.
REQ-014 SHALL have port TxDone  output  1  one-cycle pulse at end of each frame's stop period.

Function
REQ-015 SHALL implement states IDLE, LOAD, START, DATA, PARITY, STOP.
REQ-016 IDLE: when FifoEmpty=0, SHALL assert FifoRdEn for exactly one cycle and enter LOAD.
REQ-017 LOAD: SHALL capture FifoQ, WordLen, TwoStop, parity controls and Divisor; changes to these inputs mid-frame SHALL NOT affect the frame in progress.
REQ-018 START: Sout=0 for one bit period (Divisor cycles), first start cycle being the cycle after LOAD.
REQ-019 DATA: SHALL shift data LSB first, one bit per bit period, for 5/6/7/8 bits per captured WordLen; unused upper bits ignored.
REQ-020 PARITY: entered only if ParEn; bit = XOR of transmitted data bits when ParEven=1 and not ParStick, its inverse when ParEven=0 and not ParStick; with ParStick, bit = ~ParEven.
REQ-021 STOP: Sout=1 for one or two bit periods per captured TwoStop.
REQ-022 On last cycle of STOP SHALL pulse TxDone; if FifoEmpty=0 in that cycle SHALL also assert FifoRdEn and go to LOAD (no idle bit between frames), else go to IDLE.
REQ-023 Bit-period counter SHALL count Divisor-1 down to 0, reload on each bit boundary; bit period exactly max(Divisor,1) cycles.
REQ-024 FifoRdEn SHALL never assert while FifoEmpty=1.
REQ-025 SetBreak SHALL force Sout=0 combinationally-free (registered, 1-cycle latency) without altering state progression; frame data lost to break is not retransmitted.
REQ-026 Sout SHALL be driven from a flop (glitch-free).

Reset
REQ-027 While Reset_n=0: state IDLE, Sout=1, FifoRdEn=0, TxBusy=0, TxDone=0, counters and shift register cleared.
REQ-028 Reset assertion mid-frame SHALL abort the frame immediately; Sout returns high asynchronously; FIFO contents untouched.

Structure
REQ-029 State encodings and WordLen codes SHALL live in a shared UART package/include used by the receiver as well.
REQ-030 One sub-module SHALL be natural: tx_baud_counter (load/count/tick), reusable by RX.

Verification
REQ-031 Divisor=4, 8N1, FIFO holds 0x55: FifoRdEn 1 cycle, Sout = 0,1,0,1,0,1,0,1,0,1 each 4 cycles, TxDone at cycle 40 after LOAD.
REQ-032 Divisor=2, 7E2, data 0x03: 7 data bits 1100000, parity 0, two stop bits high, frame 11 bits = 22 cycles.
REQ-033 Three bytes queued, Divisor=3: back-to-back frames, start bit of frame n+1 begins 2 cycles after TxDone of frame n, FifoRdEn three times total.
REQ-034 Stick parity, ParEven=1, data 0xFF 8-bit: parity bit 0; ParEven=0: parity bit 1.
REQ-035 Reset_n pulsed low during DATA bit 3: Sout=1 immediately, state IDLE, next frame starts cleanly from FIFO head.
REQ-036 SetBreak high for 50 cycles mid-frame: Sout=0 throughout, TxDone still pulses on schedule, Sout=1 after release.
